if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- Instruction-fetch stage with IF/ID pipeline register, directly downstream of the program counter.
- Holds a 32-word instruction memory. The memory is loaded through a program port while idle. In RUN, the block reads the word addressed by the incoming 5-bit pc and registers it with its pc for decode.
- Also pre-decodes J-type jumps and returns the jump target and pc+1 to the PC logic, closing the fetch loop.

Parameters:
- ADDR_W, 5, instruction address width (matches pc width)
- DATA_W, 32, instruction word width
- DEPTH, 32, memory words (2^ADDR_W)
- HALT_WORD, 32'hFFFF_FFFF, fetched word that halts fetch

Ports:
- clk  in  1  clock; all state updates on posedge (pc changes on negedge, so it is stable half a cycle before sampling)
- rst_n  in  1  synchronous, active-low reset
- pc  in  ADDR_W  current program counter
- prog_we  in  1  program-memory write enable (honoured in IDLE only)
- prog_addr  in  ADDR_W  program write address
- prog_data  in  DATA_W  program write data
- run  in  1  single-cycle start pulse, IDLE->RUN
- stall  in  1  hold IF/ID register contents
- flush  in  1  squash IF/ID contents to bubble
- instr  out  DATA_W  registered instruction
- pc_out  out  ADDR_W  registered pc of instr
- pc_plus1  out  ADDR_W  pc_out+1, modulo 2^ADDR_W
- valid  out  1  instr/pc_out hold a live instruction
- is_jump  out  1  valid AND instr[31:26]==6'b000010
- dir_j  out  ADDR_W  instr[ADDR_W-1:0]; meaningful only when is_jump=1
- halted  out  1  FSM in HALT

Behaviour:
- Reset (rst_n=0 at posedge):
  - Outputs: instr=0, pc_out=0, pc_plus1=1, valid=0, is_jump=0, dir_j=0, halted=0.
  - FSM goes to IDLE.
  - Memory contents are NOT cleared. This applies to reset mid-RUN as well; the program survives.
- FSM states:
  - IDLE:
    - prog_we=1 writes mem[prog_addr]<=prog_data at posedge.
    - valid stays 0.
    - run=1 -> RUN at next edge. Any prog_we in that same cycle still writes.
  - RUN:
    - prog_we is ignored.
    - Each posedge with stall=0 and flush=0: instr<=mem[pc], pc_out<=pc, valid<=1.
    - If mem[pc]==HALT_WORD, the registers load normally with valid<=0 and the FSM goes to HALT.
  - HALT:
    - Registers frozen, valid=0, halted=1.
    - run, stall, flush and prog_we are all ignored.
    - Only rst_n exits (to IDLE).
- Priority in RUN, highest first:
  - rst_n
  - flush: instr<=0 (NOP), valid<=0, pc_out unchanged; no halt check.
  - stall: all registers hold.
  - normal fetch
- flush+stall in the same cycle: flush wins.
- run while already in RUN or HALT has no effect.
- Latency:
  - Memory read is combinational from pc.
  - instr is visible one posedge after pc is presented.
  - is_jump, dir_j and pc_plus1 are combinational from the registered values, so they carry no added latency.
- Arithmetic: pc_plus1 wraps 5'h1F -> 5'h00. The pc input is used as-is; all 32 addresses are valid.
- Memory read of a never-written location returns X in simulation. The bench must preload every address it fetches.

Test Plan:
- Reset, then load mem[0]=32'h2001_0005, mem[1]=32'h0800_0003, mem[3]=HALT_WORD, then pulse run. Drive pc=0 -> next posedge: instr=32'h2001_0005, pc_out=0, pc_plus1=1, valid=1, is_jump=0.
- In RUN, drive pc=1 -> instr=32'h0800_0003, is_jump=1, dir_j=5'd3. Drive pc=3 at the next edge -> valid=0, halted=1. Further pc changes leave instr=HALT_WORD unchanged.
- In RUN, hold stall=1 for 3 cycles while pc changes -> instr and pc_out frozen. Then assert flush+stall together -> instr=0, valid=0, is_jump=0.
- Write mem[1] via prog_we during RUN, then reset and read back pc=1 in RUN -> original contents. Also check that reset mid-RUN clears valid within one edge and keeps memory intact.
- Fetch with pc=5'h1F (mem preloaded) -> pc_out=5'h1F, pc_plus1=5'h00.
- After reset, assert prog_we and run in the same cycle -> write lands, FSM enters RUN, and the following fetch of that address returns the written word.

Source files
------------

// File: rtl/if_id_stage.sv
// Instruction fetch with IF/ID pipeline register: 32-word program memory loaded while idle,
// fetched by pc during RUN, with J-type pre-decode and pc+1 fed back to the PC logic.
module if_id_stage #(
  parameter int unsigned        ADDR_W    = 5,
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        DEPTH     = 32,
  parameter logic [DATA_W-1:0]  HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              run,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              valid,
  output logic              is_jump,
  output logic [ADDR_W-1:0] dir_j,
  output logic              halted
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [5:0] OP_J = 6'b000010;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] fetch_p0;
  logic [DATA_W-1:0] instr_p1;
  logic [ADDR_W-1:0] pc_p1;
  logic              vld_p1;

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  // Program memory deliberately has no reset so a program survives rst_n.
  always_ff @(posedge clk) begin
    if (rst_n && state == IDLE && prog_we)
      mem[prog_addr] <= prog_data;
  end

  assign fetch_p0 = mem[pc];

  // p0 -> p1: IF/ID register and fetch FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      instr_p1 <= '0;
      pc_p1    <= '0;
      vld_p1   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          vld_p1 <= 1'b0;
          if (run)
            state <= RUN;
        end
        RUN: begin
          if (flush) begin
            instr_p1 <= '0;
            vld_p1   <= 1'b0;
          end else if (!stall) begin
            instr_p1 <= fetch_p0;
            pc_p1    <= pc;
            if (fetch_p0 == HALT_WORD) begin
              vld_p1 <= 1'b0;
              state  <= HALT;
            end else begin
              vld_p1 <= 1'b1;
            end
          end
        end
        HALT: vld_p1 <= 1'b0;
        default: state <= IDLE;
      endcase
    end
  end

  // p1 outputs: decode is combinational from the registered word
  assign instr    = instr_p1;
  assign pc_out   = pc_p1;
  assign pc_plus1 = wrap_inc(pc_p1);
  assign valid    = vld_p1;
  assign is_jump  = vld_p1 && (instr_p1[DATA_W-1:DATA_W-6] == OP_J);
  assign dir_j    = instr_p1[ADDR_W-1:0];
  assign halted   = (state == HALT);

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: inputs change on negedge, outputs checked on negedge.
module tb_if_id_stage;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  pc;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [31:0] prog_data;
  logic        run;
  logic        stall;
  logic        flush;
  logic [31:0] instr;
  logic [4:0]  pc_out;
  logic [4:0]  pc_plus1;
  logic        valid;
  logic        is_jump;
  logic [4:0]  dir_j;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  if_id_stage dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .run(run), .stall(stall), .flush(flush), .instr(instr),
    .pc_out(pc_out), .pc_plus1(pc_plus1), .valid(valid), .is_jump(is_jump),
    .dir_j(dir_j), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic prog(input logic [4:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic start();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pc = '0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    run = 1'b0; stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    tick();
    check("rst_instr", instr, 32'h0);
    check("rst_pc_out", {27'b0, pc_out}, 32'd0);
    check("rst_pc_plus1", {27'b0, pc_plus1}, 32'd1);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_is_jump", {31'b0, is_jump}, 32'd0);
    check("rst_dir_j", {27'b0, dir_j}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    rst_n = 1'b1;

    prog(5'd0, 32'h2001_0005);
    prog(5'd1, 32'h0800_0003);
    prog(5'd2, 32'h0000_0042);
    prog(5'd3, HALT_W);
    prog(5'd31, 32'h1234_5678);
    check("idle_valid", {31'b0, valid}, 32'd0);

    // Basic fetch, jump decode and halt
    start();
    pc = 5'd0; tick();
    check("f0_instr", instr, 32'h2001_0005);
    check("f0_pc_out", {27'b0, pc_out}, 32'd0);
    check("f0_pc_plus1", {27'b0, pc_plus1}, 32'd1);
    check("f0_valid", {31'b0, valid}, 32'd1);
    check("f0_is_jump", {31'b0, is_jump}, 32'd0);
    pc = 5'd1; tick();
    check("f1_instr", instr, 32'h0800_0003);
    check("f1_is_jump", {31'b0, is_jump}, 32'd1);
    check("f1_dir_j", {27'b0, dir_j}, 32'd3);
    pc = 5'd3; tick();
    check("halt_valid", {31'b0, valid}, 32'd0);
    check("halt_halted", {31'b0, halted}, 32'd1);
    check("halt_instr", instr, HALT_W);
    check("halt_is_jump", {31'b0, is_jump}, 32'd0);
    pc = 5'd0; flush = 1'b1; run = 1'b1; tick();
    flush = 1'b0; run = 1'b0;
    check("halt_frozen_instr", instr, HALT_W);
    check("halt_frozen_pc", {27'b0, pc_out}, 32'd3);
    check("halt_still", {31'b0, halted}, 32'd1);

    // Stall then flush+stall
    do_reset();
    check("rst_exit_halted", {31'b0, halted}, 32'd0);
    start();
    pc = 5'd2; tick();
    check("f2_instr", instr, 32'h0000_0042);
    stall = 1'b1;
    pc = 5'd0; tick();
    pc = 5'd1; tick();
    pc = 5'd31; tick();
    check("stall_instr", instr, 32'h0000_0042);
    check("stall_pc_out", {27'b0, pc_out}, 32'd2);
    check("stall_valid", {31'b0, valid}, 32'd1);
    flush = 1'b1; tick();
    flush = 1'b0; stall = 1'b0;
    check("flush_instr", instr, 32'h0);
    check("flush_valid", {31'b0, valid}, 32'd0);
    check("flush_is_jump", {31'b0, is_jump}, 32'd0);
    check("flush_pc_out", {27'b0, pc_out}, 32'd2);

    // Write ignored in RUN, wrap at top address
    prog_we = 1'b1; prog_addr = 5'd1; prog_data = 32'hDEAD_BEEF;
    pc = 5'd31; tick();
    prog_we = 1'b0;
    check("wrap_instr", instr, 32'h1234_5678);
    check("wrap_pc_out", {27'b0, pc_out}, 32'd31);
    check("wrap_pc_plus1", {27'b0, pc_plus1}, 32'd0);
    pc = 5'd1; tick();
    check("run_we_ignored", instr, 32'h0800_0003);
    rst_n = 1'b0; tick();
    check("midrun_rst_valid", {31'b0, valid}, 32'd0);
    check("midrun_rst_instr", instr, 32'h0);
    rst_n = 1'b1;
    start();
    pc = 5'd1; tick();
    check("mem_survives", instr, 32'h0800_0003);
    check("mem_survives_valid", {31'b0, valid}, 32'd1);

    // prog_we and run together in IDLE
    do_reset();
    prog_we = 1'b1; prog_addr = 5'd4; prog_data = 32'h0800_0011; run = 1'b1;
    tick();
    prog_we = 1'b0; run = 1'b0;
    pc = 5'd4; tick();
    check("we_run_instr", instr, 32'h0800_0011);
    check("we_run_valid", {31'b0, valid}, 32'd1);
    check("we_run_is_jump", {31'b0, is_jump}, 32'd1);
    check("we_run_dir_j", {27'b0, dir_j}, 32'd17);
    check("we_run_pc_plus1", {27'b0, pc_plus1}, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
